// File: rtl/sop_scheduler.sv
// sop_scheduler: computes i1*i2 + i3*i4 + i5*i6 + i7*i8 with one shared
// pipelined multiplier and one shared adder, sequenced by a small FSM.
// Optional build macro SOP_SATURATE_EN: when defined, products above 32 bits
// and accumulations that carry out clamp to 32'hFFFF_FFFF instead of wrapping.
module sop_scheduler #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] i1,
  input  logic [31:0] i2,
  input  logic [31:0] i3,
  input  logic [31:0] i4,
  input  logic [31:0] i5,
  input  logic [31:0] i6,
  input  logic [31:0] i7,
  input  logic [31:0] i8,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ready_q;
  logic [31:0] ops_q [8];
  logic [31:0] pipe_q [MUL_LAT];

  logic [31:0] mulA, mulB, prodIn, accNext, prodOut;
  logic        accept;

  // A start is only honoured in IDLE and never on the first edge after reset.
  assign accept  = (state_q == IDLE) && start && ready_q;
  assign mulA    = ops_q[{k_q, 1'b0}];
  assign mulB    = ops_q[{k_q, 1'b1}];
  assign prodOut = pipe_q[MUL_LAT-1];

`ifdef SOP_SATURATE_EN
  logic [63:0] prodFull;
  logic [32:0] sumFull;
  assign prodFull = {32'd0, mulA} * {32'd0, mulB};
  assign prodIn   = (|prodFull[63:32]) ? 32'hFFFF_FFFF : prodFull[31:0];
  assign sumFull  = {1'b0, acc_q} + {1'b0, prodOut};
  assign accNext  = sumFull[32] ? 32'hFFFF_FFFF : sumFull[31:0];
`else
  assign prodIn  = mulA * mulB;
  assign accNext = acc_q + prodOut;
`endif

  // Blocks start during the edge immediately following reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  // Operand capture on the accepted start so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 8; j++) ops_q[j] <= 32'd0;
    end else if (accept) begin
      ops_q[0] <= i1;
      ops_q[1] <= i2;
      ops_q[2] <= i3;
      ops_q[3] <= i4;
      ops_q[4] <= i5;
      ops_q[5] <= i6;
      ops_q[6] <= i7;
      ops_q[7] <= i8;
    end
  end

  // Shared multiplier pipeline; the selected pair stays put for MUL_LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < MUL_LAT; j++) pipe_q[j] <= 32'd0;
    end else begin
      pipe_q[0] <= prodIn;
      for (int j = 1; j < MUL_LAT; j++) pipe_q[j] <= pipe_q[j-1];
    end
  end

  // Controller state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= 2'd0;
      cnt_q    <= 4'd0;
      acc_q    <= 32'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic: MUL waits out the multiplier, ACC folds in one product.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MUL;
          k_d     = 2'd0;
          acc_d   = 32'd0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
        end
      end
      MUL: begin
        if (cnt_q == 4'd0) state_d = ACC;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACC: begin
        acc_d = accNext;
        if (k_q != 2'd3) begin
          k_d     = k_q + 2'd1;
          cnt_d   = CNT_INIT;
          state_d = MUL;
        end else begin
          state_d  = DONE;
          result_d = accNext;
          done_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_sop_scheduler.sv
// Testbench for sop_scheduler: three instances (MUL_LAT 2, 1, 4) share the
// stimulus; expected results come from a plain-arithmetic reference model.
module tb_sop_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op [8];
  logic [31:0] result, result1, result4;
  logic        done, busy, done1, busy1, done4, busy4;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  sop_scheduler #(.MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .i1(op[0]), .i2(op[1]), .i3(op[2]), .i4(op[3]),
    .i5(op[4]), .i6(op[5]), .i7(op[6]), .i8(op[7]),
    .result(result), .done(done), .busy(busy));

  sop_scheduler #(.MUL_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .i1(op[0]), .i2(op[1]), .i3(op[2]), .i4(op[3]),
    .i5(op[4]), .i6(op[5]), .i7(op[6]), .i8(op[7]),
    .result(result1), .done(done1), .busy(busy1));

  sop_scheduler #(.MUL_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start),
    .i1(op[0]), .i2(op[1]), .i3(op[2]), .i4(op[3]),
    .i5(op[4]), .i6(op[5]), .i7(op[6]), .i8(op[7]),
    .result(result4), .done(done4), .busy(busy4));

  // Reference: sum of the four pairwise products with wrap or clamp rules.
  function automatic logic [31:0] refSop(input logic [31:0] a [8]);
    logic [63:0] p;
    logic [31:0] acc;
`ifdef SOP_SATURATE_EN
    logic [63:0] s;
    logic [31:0] term;
`endif
    acc = 32'd0;
    for (int i = 0; i < 4; i++) begin
      p = 64'(a[2*i]) * 64'(a[2*i+1]);
`ifdef SOP_SATURATE_EN
      term = (p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
      s    = 64'(acc) + 64'(term);
      acc  = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
`else
      acc = acc + p[31:0];
`endif
    end
    return acc;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setBasic;
    op = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd3, 32'd1, 32'd3, 32'd2};
  endtask

  task automatic setOnes;
    op = '{default: 32'd1};
  endtask

  // One-cycle start pulse; returns just after the accepting edge.
  task automatic applyStimulus;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges until done is seen; -1 if the bound expires.
  task automatic waitDone(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 200);
    if (done !== 1'b1) n = -1;
  endtask

  task automatic waitAllIdle;
    int g;
    g = 0;
    while ((busy || busy1 || busy4) && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) begin
      total++;
      bad++;
      $display("[TB] FAIL idle_timeout: got busy after %0d cycles required idle", g);
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    start = 1'b0;
    setBasic();
    repeat (2) tick();
    total++; if (result !== 32'd0) begin bad++; $display("[TB] FAIL reset_result: got %0h expected 0", result); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    rst = 1'b0;
    start = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL start_at_release: got busy=%0b expected 0", busy); end
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL start_after_release: got busy=%0b expected 1", busy); end
    waitDone(n);
    total++; if (n !== 12) begin bad++; $display("[TB] FAIL release_latency: got %0d expected 12", n); end
  endtask

  task automatic test_basic;
    int n, pulses;
    bit busyOk;
    logic [31:0] exp;
    waitAllIdle();
    setBasic();
    exp = refSop(op);
    applyStimulus();
    busyOk = (busy === 1'b1);
    n = 0;
    do begin
      tick();
      n++;
      if (busy !== 1'b1) busyOk = 1'b0;
    end while (done !== 1'b1 && n < 200);
    total++; if (n !== 12) begin bad++; $display("[TB] FAIL basic_latency: got %0d expected 12", n); end
    total++; if (result !== exp || exp !== 32'd17) begin bad++; $display("[TB] FAIL basic_result: got %0d expected 17", result); end
    total++; if (!busyOk) begin bad++; $display("[TB] FAIL basic_busy: got low during job expected high"); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL basic_done_fall: got %0b expected 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_fall: got %0b expected 0", busy); end
    pulses = 0;
    repeat (10) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL basic_extra_done: got %0d pulses expected 0", pulses); end
    total++; if (result !== exp) begin bad++; $display("[TB] FAIL basic_hold: got %0d expected %0d", result, exp); end
  endtask

  task automatic test_latency_sweep;
    int n1, n2, n4;
    logic [31:0] r1, r2, r4, exp;
    waitAllIdle();
    setBasic();
    exp = refSop(op);
    applyStimulus();
    n1 = -1; n2 = -1; n4 = -1;
    r1 = '0; r2 = '0; r4 = '0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (done === 1'b1 && n2 < 0) begin n2 = c; r2 = result; end
      if (done1 === 1'b1 && n1 < 0) begin n1 = c; r1 = result1; end
      if (done4 === 1'b1 && n4 < 0) begin n4 = c; r4 = result4; end
    end
    total++; if (n1 !== 8) begin bad++; $display("[TB] FAIL lat1_latency: got %0d expected 8", n1); end
    total++; if (n2 !== 12) begin bad++; $display("[TB] FAIL lat2_latency: got %0d expected 12", n2); end
    total++; if (n4 !== 20) begin bad++; $display("[TB] FAIL lat4_latency: got %0d expected 20", n4); end
    total++; if (r1 !== exp) begin bad++; $display("[TB] FAIL lat1_result: got %0d expected %0d", r1, exp); end
    total++; if (r2 !== exp) begin bad++; $display("[TB] FAIL lat2_result: got %0d expected %0d", r2, exp); end
    total++; if (r4 !== exp) begin bad++; $display("[TB] FAIL lat4_result: got %0d expected %0d", r4, exp); end
  endtask

  task automatic test_busy_ignore;
    int n;
    logic [31:0] exp1, exp2;
    waitAllIdle();
    setBasic();
    exp1 = refSop(op);
    start = 1'b1;
    tick();
    setOnes();
    exp2 = refSop(op);
    waitDone(n);
    total++; if (n !== 12) begin bad++; $display("[TB] FAIL ignore_latency: got %0d expected 12", n); end
    total++; if (result !== exp1) begin bad++; $display("[TB] FAIL ignore_capture: got %0d expected %0d", result, exp1); end
    waitDone(n);
    total++; if (n !== 14) begin bad++; $display("[TB] FAIL ignore_period: got %0d expected 14", n); end
    total++; if (result !== exp2) begin bad++; $display("[TB] FAIL ignore_second: got %0d expected %0d", result, exp2); end
    start = 1'b0;
  endtask

  task automatic test_overflow;
    int n;
    logic [31:0] exp;
    waitAllIdle();
    op = '{32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    exp = refSop(op);
    applyStimulus();
    waitDone(n);
    total++; if (result !== exp) begin bad++; $display("[TB] FAIL ovf_product: got %0h expected %0h", result, exp); end
    waitAllIdle();
    op = '{32'hFFFF_FFFF, 32'd1, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
    exp = refSop(op);
    applyStimulus();
    waitDone(n);
    total++; if (result !== exp) begin bad++; $display("[TB] FAIL ovf_sum: got %0h expected %0h", result, exp); end
    total++; if (n !== 12) begin bad++; $display("[TB] FAIL ovf_latency: got %0d expected 12", n); end
  endtask

  task automatic test_reset_mid;
    int n, pulses;
    logic [31:0] exp;
    waitAllIdle();
    setBasic();
    exp = refSop(op);
    applyStimulus();
    repeat (4) tick();
    rst = 1'b1;
    #1;
    total++; if (result !== 32'd0) begin bad++; $display("[TB] FAIL abort_result: got %0h expected 0", result); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL abort_done: got %0b expected 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %0b expected 0", busy); end
    tick();
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", pulses); end
    applyStimulus();
    waitDone(n);
    total++; if (n !== 12) begin bad++; $display("[TB] FAIL abort_fresh_latency: got %0d expected 12", n); end
    total++; if (result !== exp) begin bad++; $display("[TB] FAIL abort_fresh_result: got %0d expected %0d", result, exp); end
  endtask

  task automatic test_back_to_back;
    int n;
    bit holdOk;
    logic [31:0] exp1, exp2;
    waitAllIdle();
    setBasic();
    exp1 = refSop(op);
    applyStimulus();
    waitDone(n);
    tick();
    setOnes();
    exp2 = refSop(op);
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept: got busy=%0b expected 1", busy); end
    holdOk = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (result !== exp1) holdOk = 1'b0;
      tick();
      n++;
    end
    total++; if (!holdOk) begin bad++; $display("[TB] FAIL b2b_hold: got changed result expected %0d held", exp1); end
    total++; if (n !== 12) begin bad++; $display("[TB] FAIL b2b_latency: got %0d expected 12", n); end
    total++; if (result !== exp2) begin bad++; $display("[TB] FAIL b2b_result: got %0d expected %0d", result, exp2); end
  endtask

  task automatic test_random;
    int n;
    logic [31:0] exp;
    for (int t = 0; t < 8; t++) begin
      waitAllIdle();
      for (int j = 0; j < 8; j++)
        op[j] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4095));
      exp = refSop(op);
      applyStimulus();
      for (int j = 0; j < 8; j++) op[j] = $urandom;
      waitDone(n);
      total++; if (n !== 12) begin bad++; $display("[TB] FAIL rand%0d_latency: got %0d expected 12", t, n); end
      total++; if (result !== exp) begin bad++; $display("[TB] FAIL rand%0d_result: got %0h expected %0h", t, result, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency_sweep();
    test_busy_ignore();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
